// File: rtl/wave_pwm_dac_pkg.sv
// Shared types and constants for the wave-to-PWM DAC and its extremum detector.
package wave_pwm_dac_pkg;

  localparam int SAMPLE_W   = 5;
  localparam int PWM_PERIOD = 32;
  localparam int CNT_W      = $clog2(PWM_PERIOD);

  // Last count value of a PWM period; the edge leaving it is the wrap edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/wave_extremum_det.sv
// Peak/trough detector over the stream of captured samples. Tracks the last
// sample and the current direction, pulses once when the direction reverses,
// and counts troughs (one per completed triangle).
module wave_extremum_det
  import wave_pwm_dac_pkg::*;
#(
  parameter int CYC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_capture,
  input  sample_t          i_sample,
  output logic             o_peak,
  output logic             o_trough,
  output logic [CYC_W-1:0] o_cycle_count
);

  sample_t          r_prev;
  logic             r_rising;
  logic             r_first;
  logic             r_peak;
  logic             r_trough;
  logic [CYC_W-1:0] r_cycleCount;

  // Compare each captured sample with the previous one; equal samples change nothing.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev       <= '0;
      r_rising     <= 1'b1;
      r_first      <= 1'b1;
      r_peak       <= 1'b0;
      r_trough     <= 1'b0;
      r_cycleCount <= '0;
    end else begin
      r_peak   <= 1'b0;
      r_trough <= 1'b0;
      if (i_capture) begin
        if (r_first) begin
          r_prev  <= i_sample;
          r_first <= 1'b0;
        end else if (i_sample > r_prev) begin
          r_prev   <= i_sample;
          r_rising <= 1'b1;
          if (!r_rising) begin
            r_trough     <= 1'b1;
            r_cycleCount <= r_cycleCount + CYC_W'(1);
          end
        end else if (i_sample < r_prev) begin
          r_prev   <= i_sample;
          r_rising <= 1'b0;
          if (r_rising) begin
            r_peak <= 1'b1;
          end
        end
      end
    end
  end

  assign o_peak        = r_peak;
  assign o_trough      = r_trough;
  assign o_cycle_count = r_cycleCount;

endmodule

// File: rtl/wave_pwm_dac.sv
// wave_pwm_dac: converts a 5-bit sample stream into a 32-cycle PWM waveform.
// A sample captured during a period is held as pending and becomes the duty
// on the next wrap; sticky flags report overwritten and missing samples.
module wave_pwm_dac
  import wave_pwm_dac_pkg::*;
#(
  parameter int CYC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [SAMPLE_W-1:0] i_wave,
  input  logic             i_wave_valid,
  input  logic             i_clr_flags,
  output logic             o_pwm_out,
  output logic             o_period_start,
  output logic             o_peak,
  output logic             o_trough,
  output logic [CYC_W-1:0] o_cycle_count,
  output logic             o_sample_ovf,
  output logic             o_sample_udf
);

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  sample_t          r_duty;
  sample_t          w_dutyNext;
  sample_t          r_pending;
  sample_t          w_pendingNext;
  logic             r_pendingValid;
  logic             w_pendingValidNext;
  logic             w_wrap;
  logic             w_capture;
  logic             w_ovfSet;
  logic             w_udfSet;
  logic             r_pwmOut;
  logic             r_periodStart;
  logic             r_sampleOvf;
  logic             r_sampleUdf;

  // Next-state, counter, duty and pending-sample logic. On a wrap the old
  // pending sample is consumed before a same-edge capture refills it, so a
  // capture on the wrap edge never counts as an overwrite.
  always_comb begin
    w_stateNext        = r_state;
    w_cntNext          = '0;
    w_dutyNext         = r_duty;
    w_pendingNext      = r_pending;
    w_pendingValidNext = r_pendingValid;
    w_wrap             = 1'b0;
    w_capture          = 1'b0;
    w_ovfSet           = 1'b0;
    w_udfSet           = 1'b0;
    case (r_state)
      IDLE: begin
        w_pendingValidNext = 1'b0;
        if (i_en) begin
          w_stateNext = RUN;
          if (r_pendingValid) begin
            w_dutyNext = r_pending;
          end
        end
      end
      RUN: begin
        if (!i_en) begin
          w_stateNext        = IDLE;
          w_pendingValidNext = 1'b0;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
          w_wrap    = (r_cnt == CNT_LAST);
          w_capture = i_wave_valid;
          if (w_wrap) begin
            if (r_pendingValid) begin
              w_dutyNext         = r_pending;
              w_pendingValidNext = 1'b0;
            end else begin
              w_udfSet = 1'b1;
            end
          end
          if (i_wave_valid) begin
            w_ovfSet           = r_pendingValid && !w_wrap;
            w_pendingNext      = i_wave;
            w_pendingValidNext = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register plus datapath; PWM and period-start are registered from
  // next-state values so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_duty         <= '0;
      r_pending      <= '0;
      r_pendingValid <= 1'b0;
      r_pwmOut       <= 1'b0;
      r_periodStart  <= 1'b0;
    end else begin
      r_state        <= w_stateNext;
      r_cnt          <= w_cntNext;
      r_duty         <= w_dutyNext;
      r_pending      <= w_pendingNext;
      r_pendingValid <= w_pendingValidNext;
      r_pwmOut       <= (w_stateNext == RUN) && (w_cntNext < w_dutyNext);
      r_periodStart  <= (w_stateNext == RUN) && (w_cntNext == '0);
    end
  end

  // Sticky error flags; a new event on the same edge as a clear keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sampleOvf <= 1'b0;
      r_sampleUdf <= 1'b0;
    end else begin
      r_sampleOvf <= w_ovfSet | (r_sampleOvf & ~i_clr_flags);
      r_sampleUdf <= w_udfSet | (r_sampleUdf & ~i_clr_flags);
    end
  end

  wave_extremum_det #(
    .CYC_W(CYC_W)
  ) u_extremumDet (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_capture    (w_capture),
    .i_sample     (i_wave),
    .o_peak       (o_peak),
    .o_trough     (o_trough),
    .o_cycle_count(o_cycle_count)
  );

  assign o_pwm_out      = r_pwmOut;
  assign o_period_start = r_periodStart;
  assign o_sample_ovf   = r_sampleOvf;
  assign o_sample_udf   = r_sampleUdf;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Testbench for wave_pwm_dac: a behavioural period/sample model checked every
// cycle, plus hand-computed expectations for duty, flags and extremum counts.
module tb_wave_pwm_dac;

  localparam int PERIOD = 32;
  localparam int CYC_W  = 8;

  logic             clk;
  logic             rstN;
  logic             en;
  logic [4:0]       wave;
  logic             waveValid;
  logic             clrFlags;
  logic             pwmOut;
  logic             periodStart;
  logic             peak;
  logic             trough;
  logic [CYC_W-1:0] cycleCount;
  logic             sampleOvf;
  logic             sampleUdf;

  int passCount  = 0;
  int checkCount = 0;

  wave_pwm_dac #(
    .CYC_W(CYC_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_en          (en),
    .i_wave        (wave),
    .i_wave_valid  (waveValid),
    .i_clr_flags   (clrFlags),
    .o_pwm_out     (pwmOut),
    .o_period_start(periodStart),
    .o_peak        (peak),
    .o_trough      (trough),
    .o_cycle_count (cycleCount),
    .o_sample_ovf  (sampleOvf),
    .o_sample_udf  (sampleUdf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    else
      passCount++;
  endtask

  // Behavioural model: running flag, position in the period, duty in force,
  // at most one waiting sample, sticky flags, and direction tracking.
  bit mRun;
  int mCnt;
  int mDuty;
  int mPend;
  bit mPendV;
  int mPrev;
  bit mRising;
  bit mFirst;
  int mCount;
  bit mPeak;
  bit mTrough;
  bit mOvf;
  bit mUdf;
  bit modelKnown = 1'b0;

  // Model advances on the same edge as the DUT using the inputs held since the falling edge.
  always @(posedge clk) begin
    bit overwrite;
    bit starved;
    bit capture;
    if (!rstN) begin
      mRun = 0; mCnt = 0; mDuty = 0; mPend = 0; mPendV = 0;
      mPrev = 0; mRising = 1; mFirst = 1; mCount = 0;
      mPeak = 0; mTrough = 0; mOvf = 0; mUdf = 0;
      modelKnown = 1'b1;
    end else begin
      overwrite = 0;
      starved   = 0;
      mPeak     = 0;
      mTrough   = 0;
      capture   = mRun && en && waveValid;
      if (mRun && en) begin
        if (mCnt == PERIOD - 1) begin
          if (mPendV) begin
            mDuty  = mPend;
            mPendV = 0;
          end else begin
            starved = 1;
          end
        end
        mCnt = (mCnt + 1) % PERIOD;
        if (waveValid) begin
          overwrite = mPendV;
          mPend     = wave;
          mPendV    = 1;
        end
      end else begin
        mRun   = en;
        mCnt   = 0;
        mPendV = 0;
      end
      if (capture) begin
        if (mFirst) begin
          mFirst = 0;
          mPrev  = wave;
        end else if (int'(wave) > mPrev) begin
          if (!mRising) begin
            mTrough = 1;
            mCount  = (mCount + 1) % (1 << CYC_W);
          end
          mRising = 1;
          mPrev   = wave;
        end else if (int'(wave) < mPrev) begin
          if (mRising) mPeak = 1;
          mRising = 0;
          mPrev   = wave;
        end
      end
      mOvf = overwrite || (mOvf && !clrFlags);
      mUdf = starved || (mUdf && !clrFlags);
    end
  end

  // Every cycle, compare all outputs against the model.
  always @(negedge clk) begin
    if (modelKnown) begin
      checkOutput("pwm_out", pwmOut, mRun && (mCnt < mDuty));
      checkOutput("period_start", periodStart, mRun && (mCnt == 0));
      checkOutput("peak", peak, mPeak);
      checkOutput("trough", trough, mTrough);
      checkOutput("cycle_count", cycleCount, mCount);
      checkOutput("sample_ovf", sampleOvf, mOvf);
      checkOutput("sample_udf", sampleUdf, mUdf);
    end
  end

  // Per-period statistics taken from the DUT outputs: high cycles and length.
  int hist[$];
  int curHigh = 0;
  int curLen  = 0;
  int lastLen = 0;
  int peakCnt = 0;
  int troughCnt = 0;

  always @(negedge clk) begin
    if (periodStart === 1'b1) begin
      hist.push_back(curHigh);
      lastLen = curLen;
      curHigh = 0;
      curLen  = 0;
    end
    curLen++;
    if (pwmOut === 1'b1) curHigh++;
    if (peak === 1'b1) peakCnt++;
    if (trough === 1'b1) troughCnt++;
  end

  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic c, input logic [4:0] w);
    @(negedge clk);
    rstN      = r;
    en        = e;
    waveValid = v;
    clrFlags  = c;
    wave      = w;
  endtask

  task automatic runCycles(input int n, input logic e, input logic v, input logic [4:0] w);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, e, v, 1'b0, w);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  int peakBase;
  int troughBase;
  int guard;

  initial begin
    rstN = 1'b0; en = 1'b0; waveValid = 1'b0; clrFlags = 1'b0; wave = '0;

    // Reset state
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    settle();
    checkOutput("reset pwm_out", pwmOut, 0);
    checkOutput("reset period_start", periodStart, 0);
    checkOutput("reset cycle_count", cycleCount, 0);
    checkOutput("reset flags", {sampleOvf, sampleUdf}, 0);

    // One sample of 8 in period 1 drives period 2 at 8/32
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
    runCycles(31, 1'b1, 1'b0, 5'd0);
    runCycles(32, 1'b1, 1'b0, 5'd0);
    runCycles(1, 1'b1, 1'b0, 5'd0);
    settle();
    checkOutput("period1 high", hist[$-1], 0);
    checkOutput("period2 high", hist[$], 8);
    checkOutput("period length", lastLen, 32);
    checkOutput("udf after starved wrap", sampleUdf, 1);
    checkOutput("no ovf yet", sampleOvf, 0);

    // Duty 0 then duty 31 in consecutive periods
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
    runCycles(30, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd31);
    runCycles(31, 1'b1, 1'b0, 5'd0);
    runCycles(32, 1'b1, 1'b0, 5'd0);
    runCycles(1, 1'b1, 1'b0, 5'd0);
    settle();
    checkOutput("held duty high", hist[$-2], 8);
    checkOutput("duty0 high", hist[$-1], 0);
    checkOutput("duty31 high", hist[$], 31);

    // Two captures in one period: newest wins and overrun is flagged
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd9);
    settle();
    checkOutput("ovf after double capture", sampleOvf, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd0);
    settle();
    checkOutput("ovf cleared", sampleOvf, 0);
    runCycles(27, 1'b1, 1'b0, 5'd0);
    runCycles(32, 1'b1, 1'b0, 5'd0);
    runCycles(1, 1'b1, 1'b0, 5'd0);
    settle();
    checkOutput("newest sample duty", hist[$], 9);
    checkOutput("udf after idle period", sampleUdf, 1);

    // Capture on the wrap edge is not an overrun
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd12);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd0);
    runCycles(28, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd20);
    settle();
    checkOutput("wrap capture ovf", sampleOvf, 0);
    checkOutput("wrap capture udf", sampleUdf, 0);
    runCycles(32, 1'b1, 1'b0, 5'd0);
    runCycles(1, 1'b1, 1'b0, 5'd0);
    settle();
    checkOutput("consumed duty", hist[$], 12);

    // Two full triangles then a final valley
    peakBase   = peakCnt;
    troughBase = troughCnt;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'(i));
      for (int i = 30; i > 0; i--) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'(i));
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    settle();
    checkOutput("triangle peaks", peakCnt - peakBase, 3);
    checkOutput("triangle troughs", troughCnt - troughBase, 3);
    checkOutput("triangle cycle_count", cycleCount, 5);

    // Drop enable at count 17
    guard = 0;
    while (!(mRun && mCnt == 16) && guard < 64) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      guard++;
    end
    checkOutput("reach count 16", guard < 64, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    settle();
    checkOutput("en drop pwm_out", pwmOut, 0);
    checkOutput("en drop period_start", periodStart, 0);
    runCycles(3, 1'b0, 1'b1, 5'd3);
    settle();
    checkOutput("count kept in idle", cycleCount, 5);

    // Reset in the middle of a running period with flags set
    runCycles(10, 1'b1, 1'b1, 5'd25);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd7);
    settle();
    checkOutput("mid reset pwm_out", pwmOut, 0);
    checkOutput("mid reset period_start", periodStart, 0);
    checkOutput("mid reset pulses", {peak, trough}, 0);
    checkOutput("mid reset cycle_count", cycleCount, 0);
    checkOutput("mid reset flags", {sampleOvf, sampleUdf}, 0);

    // Restart after reset: first capture only seeds the detector
    runCycles(40, 1'b1, 1'b1, 5'd7);
    runCycles(5, 1'b1, 1'b1, 5'd2);
    settle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
